// File: rtl/hist_stats.sv
// Histogram frame statistics: collects one dump frame of bin counts, then reports
// peak bin, peak value, total and non-zero bin count as four handshaked bytes.
module hist_stats #(
  parameter int NUM_BINS = 32,
  parameter int COUNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  input  logic       err_clr
);

  localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  typedef enum logic {COLLECT, REPORT} state_t;

  state_t               state_q,     state_d;
  logic [IDX_W-1:0]     bin_idx_q,   bin_idx_d;
  logic [8:0]           sum_q,       sum_d;
  logic [COUNT_W-1:0]   max_val_q,   max_val_d;
  logic [IDX_W-1:0]     max_idx_q,   max_idx_d;
  logic [5:0]           nz_q,        nz_d;
  logic [1:0]           ptr_q,       ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_data_q,  out_data_d;
  logic                 out_last_q,  out_last_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q,   overrun_d;

  logic [COUNT_W-1:0]   count;
  logic                 at_last_bin;
  logic                 unused_in;

  assign count       = in_data[COUNT_W-1:0];
  assign at_last_bin = (bin_idx_q == LAST_IDX);
  assign unused_in   = ^in_data;

  function automatic logic [7:0] report_byte(
    input logic [1:0]         sel,
    input logic [IDX_W-1:0]   midx,
    input logic [COUNT_W-1:0] mval,
    input logic [8:0]         s,
    input logic [5:0]         n
  );
    case (sel)
      2'd0:    report_byte = 8'(midx);
      2'd1:    report_byte = 8'(mval);
      2'd2:    report_byte = s[7:0];
      default: report_byte = {s[8], 1'b0, n};
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    bin_idx_d   = bin_idx_q;
    sum_d       = sum_q;
    max_val_d   = max_val_q;
    max_idx_d   = max_idx_q;
    nz_d        = nz_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    // Flag sets below override the clear, so an error coincident with err_clr sticks.
    frame_err_d = frame_err_q && !err_clr;
    overrun_d   = overrun_q && !err_clr;

    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          if (in_last != at_last_bin) begin
            frame_err_d = 1'b1;
            bin_idx_d   = '0;
            sum_d       = '0;
            max_val_d   = '0;
            max_idx_d   = '0;
            nz_d        = '0;
          end else begin
            sum_d = sum_q + 9'(count);
            if (count > max_val_q) begin
              max_val_d = count;
              max_idx_d = bin_idx_q;
            end
            if (count != '0) nz_d = nz_q + 6'd1;
            if (in_last) begin
              state_d     = REPORT;
              bin_idx_d   = '0;
              ptr_d       = 2'd0;
              out_valid_d = 1'b1;
              out_last_d  = 1'b0;
              // First byte comes from the post-update stats so it is ready one clock later.
              out_data_d  = report_byte(2'd0, max_idx_d, max_val_d, sum_d, nz_d);
            end else begin
              bin_idx_d = bin_idx_q + 1'b1;
            end
          end
        end
      end
      REPORT: begin
        if (in_valid) overrun_d = 1'b1;
        if (out_valid_q && out_ready) begin
          if (ptr_q == 2'd3) begin
            state_d     = COLLECT;
            ptr_d       = 2'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_data_d  = 8'd0;
            bin_idx_d   = '0;
            sum_d       = '0;
            max_val_d   = '0;
            max_idx_d   = '0;
            nz_d        = '0;
          end else begin
            ptr_d      = ptr_q + 2'd1;
            out_data_d = report_byte(ptr_d, max_idx_q, max_val_q, sum_q, nz_q);
            out_last_d = (ptr_d == 2'd3);
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      bin_idx_q   <= '0;
      sum_q       <= '0;
      max_val_q   <= '0;
      max_idx_q   <= '0;
      nz_q        <= '0;
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_idx_q   <= bin_idx_d;
      sum_q       <= sum_d;
      max_val_q   <= max_val_d;
      max_idx_q   <= max_idx_d;
      nz_q        <= nz_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == REPORT);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_hist_stats.sv
// Bench for hist_stats: frame-level reference model checked every cycle, plus
// directed scenarios with literal report bytes and randomized traffic.
module tb_hist_stats;

  localparam int NB = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic       err_clr = 1'b0;
  logic       out_valid, out_last, busy, frame_err, overrun;
  logic [7:0] out_data;

  hist_stats #(.NUM_BINS(NB), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_last(out_last), .busy(busy),
    .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: the frame so far, and the report bytes once a frame is complete.
  int   m_frame[$];
  bit   m_rep = 0;
  int   m_ptr = 0;
  int   m_bytes[4];
  bit   m_ferr = 0;
  bit   m_ovr = 0;
  int   got[$];

  task automatic model_build();
    int mx, mi, s, nz;
    mx = 0; mi = 0; s = 0; nz = 0;
    for (int i = 0; i < m_frame.size(); i++) begin
      s += m_frame[i];
      if (m_frame[i] != 0) nz++;
      if (m_frame[i] > mx) begin mx = m_frame[i]; mi = i; end
    end
    m_bytes[0] = mi;
    m_bytes[1] = mx;
    m_bytes[2] = s % 256;
    m_bytes[3] = ((s / 256) % 2) * 128 + nz;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      m_frame.delete();
      m_rep = 0; m_ptr = 0; m_ferr = 0; m_ovr = 0;
    end else begin
      bit nf, no, at_end;
      chk("out_valid", out_valid, m_rep);
      chk("busy", busy, m_rep);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
      if (m_rep) begin
        chk("out_data", out_data, m_bytes[m_ptr]);
        chk("out_last", out_last, (m_ptr == 3));
        if (out_ready) got.push_back(int'(out_data));
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      nf = m_ferr && !err_clr;
      no = m_ovr && !err_clr;
      if (m_rep) begin
        if (in_valid) no = 1;
        if (out_ready) begin
          m_ptr++;
          if (m_ptr == 4) begin m_rep = 0; m_ptr = 0; end
        end
      end else if (in_valid) begin
        at_end = (m_frame.size() == NB - 1);
        if (in_last != at_end) begin
          nf = 1;
          m_frame.delete();
        end else begin
          m_frame.push_back(int'(in_data[3:0]));
          if (in_last) begin
            model_build();
            m_rep = 1; m_ptr = 0;
            m_frame.delete();
          end
        end
      end
      m_ferr = nf;
      m_ovr = no;
    end
  end

  task automatic beat(input logic [3:0] c, input logic l);
    logic [3:0] up;
    up = 4'($urandom_range(0, 15));
    in_valid = 1'b1; in_data = {up, c}; in_last = l;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_frame(input int kind);
    logic [3:0] c;
    for (int i = 0; i < NB; i++) begin
      case (kind)
        0: c = 4'(i % 16);
        1: c = 4'd15;
        default: c = (i == 7 || i == 20) ? 4'd9 : 4'd0;
      endcase
      beat(c, (i == NB - 1));
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_rep && k < 200) begin @(posedge clk); k++; end
    #1;
    if (k >= 200) chk("report_timeout", 1, 0);
  endtask

  task automatic check_got(input string nm, input int b0, input int b1, input int b2, input int b3);
    int e[4];
    e[0] = b0; e[1] = b1; e[2] = b2; e[3] = b3;
    chk({nm, "_count"}, got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk({nm, "_byte"}, got[i], e[i]);
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
  endtask

  initial begin
    int pos;
    bit vld, lst;
    logic [3:0] c;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_valid", out_valid, 0);

    // Scenario 1: ramp pattern, latency of one clock.
    got.delete();
    send_frame(0);
    chk("s1_latency_valid", out_valid, 1);
    chk("s1_b0_now", out_data, 8'h0F);
    wait_idle();
    check_got("s1", 8'h0F, 8'h0F, 8'hF0, 8'h1E);

    // Scenario 4 then 2: short frame, then a clean all-15 frame.
    for (int i = 0; i <= 10; i++) beat(4'd3, (i == 10));
    chk("s4_frame_err", frame_err, 1);
    chk("s4_no_output", out_valid, 0);
    got.delete();
    send_frame(1);
    wait_idle();
    check_got("s2", 8'h00, 8'h0F, 8'hE0, 8'hA0);
    pulse_clr();
    chk("s4_err_clr", frame_err, 0);

    // Scenario 5: stall on b1 with an overrun beat.
    got.delete();
    send_frame(0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("s5_b1_shown", out_data, 8'h0F);
    beat(4'd5, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("s5_b1_held", out_data, 8'h0F);
    chk("s5_overrun", overrun, 1);
    out_ready = 1'b1;
    wait_idle();
    check_got("s5", 8'h0F, 8'h0F, 8'hF0, 8'h1E);
    pulse_clr();

    // Scenario 6: reset after b1 accepted, then a fresh frame.
    send_frame(1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("s6_valid", out_valid, 0);
    chk("s6_data", out_data, 0);
    chk("s6_last", out_last, 0);
    chk("s6_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    got.delete();
    send_frame(2);
    wait_idle();
    check_got("s3", 8'h07, 8'h09, 8'h12, 8'h02);

    // Randomized traffic with stalls, overruns, bad lengths and flag clears.
    pos = 0;
    for (int n = 0; n < 4000; n++) begin
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr = ($urandom_range(0, 49) == 0);
      vld = m_rep ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      lst = 0;
      if (vld && !m_rep) begin
        lst = (pos == NB - 1) ^ ($urandom_range(0, 99) == 0);
        pos = (lst || pos == NB - 1) ? 0 : pos + 1;
      end
      in_valid = vld;
      in_data = {4'($urandom_range(0, 15)), c};
      in_last = lst;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hist_stats.md
HIST_STATS -- requirements
Module: hist_stats

Interface
REQ-001 SHALL have parameter NUM_BINS, default 32, the number of bins per histogram dump frame.
REQ-002 SHALL have parameter COUNT_W, default 4, the width of the bin count field carried in in_data[COUNT_W-1:0].
REQ-003 SHALL use one clock and an asynchronous active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  one bin count is present on in_data this cycle; no backpressure toward the source.
REQ-007 in_data  input  8  bin count, low COUNT_W bits used, upper bits ignored.
REQ-008 in_last  input  1  marks the final bin of a dump frame; qualified by in_valid.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_valid  output  1  out_data holds a report byte.
REQ-011 out_data  output  8  report byte.
REQ-012 out_last  output  1  marks the final report byte.
REQ-013 busy  output  1  high while in REPORT.
REQ-014 frame_err  output  1  sticky flag: a frame had bad length.
REQ-015 overrun  output  1  sticky flag: an input beat arrived during REPORT.
REQ-016 err_clr  input  1  synchronous clear of frame_err and overrun.

Function
REQ-017 SHALL implement the states COLLECT and REPORT, and SHALL enter COLLECT from reset.
REQ-018 COLLECT: each in_valid beat SHALL be bin number bin_idx, where bin_idx counts 0..NUM_BINS-1, resets to 0 at the start of each frame, and is log2(NUM_BINS) bits wide.
REQ-019 Per beat: sum += count, with sum 9 bits wide (max 32*15=480, no saturation required).
REQ-020 Per beat: if count > max_val, then max_val=count and max_idx=bin_idx; ties SHALL keep the lowest index; an all-zero frame SHALL give max_idx=0 and max_val=0.
REQ-021 Per beat: nz += 1 when count != 0, with nz 6 bits wide.
REQ-022 A beat with in_last=1 and bin_idx==NUM_BINS-1 SHALL include that beat in the stats and go to REPORT on the next edge.
REQ-023 A beat with in_last=1 and bin_idx!=NUM_BINS-1 SHALL set frame_err, discard all accumulators, and stay in COLLECT with bin_idx=0.
REQ-024 A beat with in_last=0 and bin_idx==NUM_BINS-1 SHALL set frame_err, discard all accumulators, and stay in COLLECT with bin_idx=0.
REQ-025 REPORT SHALL present 4 bytes in order:
- b0 = {3'b0, max_idx}
- b1 = {4'b0, max_val}
- b2 = sum[7:0]
- b3 = {sum[8], 1'b0, nz}
REQ-026 out_valid SHALL rise in the first cycle after the accepting last beat, giving a latency of 1 clock.
REQ-027 A byte SHALL advance only on an out_valid&&out_ready edge, and out_data/out_last SHALL hold stable while out_valid&&!out_ready.
REQ-028 out_last SHALL be 1 only with b3.
REQ-029 When b3 is accepted, the block SHALL clear all accumulators, return to COLLECT, and drop out_valid on the next cycle.
REQ-030 An in_valid beat during REPORT SHALL be dropped and SHALL set overrun, with no effect on the report in progress.
REQ-031 The block SHALL accept a frame beginning the cycle after b3 is accepted.
REQ-032 err_clr SHALL clear frame_err and overrun on the next edge.
REQ-033 If an error event occurs in the same cycle as err_clr, the flag SHALL be set, because set wins.
REQ-034 busy SHALL equal (state==REPORT).
REQ-035 The block SHALL contain no combinational path from in_* to out_*.

Reset
REQ-036 rst_n low SHALL immediately clear the following, regardless of the cycle or state:
- out_valid, out_last, busy, frame_err, overrun = 0
- out_data = 0
- state = COLLECT
- bin_idx, sum, max_val, max_idx, nz = 0
REQ-037 A reset during COLLECT or REPORT SHALL abandon the partial frame or report without emitting any further output.
REQ-038 The block SHALL drive no output transitions while rst_n is low, and SHALL accept a beat on the first edge after rst_n deasserts.

Verification
REQ-039 Scenario 1: 32 beats with count=i%16, last on beat 31, out_ready=1 -> bytes 0x0F,0x0F,0xF0,0x1E (sum 240, nz 30), out_last on the 4th byte, out_valid 1 cycle after the last beat.
REQ-040 Scenario 2: all counts 15 -> bytes 0x00,0x0F,0xE0,0xA0 (sum 480, so sum[8]=1; nz=32).
REQ-041 Scenario 3: bin 7=9, bin 20=9, all others 0 -> max_idx 7; bytes 0x07,0x09,0x12,0x02.
REQ-042 Scenario 4: in_last on beat 10 -> frame_err=1 and no output; a following good 32-beat frame reports only its own data; err_clr -> frame_err=0.
REQ-043 Scenario 5: out_ready low for 5 cycles on b1, plus an in_valid beat during REPORT -> b1 held stable, all 4 bytes delivered unchanged, overrun=1.
REQ-044 Scenario 6: rst_n pulse mid-REPORT after b1 -> all outputs 0 immediately, then a fresh frame reports correctly.
